// File: rtl/servo_ramp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : servo_ramp_sequencer
//  Description : Host-programmable servo position ramper. On each enabled
//                frame tick every channel's position is stepped toward its
//                target, one channel per cycle, then all positions are
//                published to the PWM generator in a single commit cycle.
//                Optional feature macro: SERVO_RAMP_IRQ_EN enables the
//                ArrivePend/Overrun status bits and the Irq output.
//  Revision    : 1.0  initial release
// ============================================================================
module servo_ramp_sequencer #(
    parameter int NUM_SERVO = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [4:0]             Addr,
    input  logic [15:0]            DataWr,
    output logic [15:0]            DataRd,
    input  logic                   En,
    input  logic                   Wr,
    input  logic                   FrameTick,
    output logic [NUM_SERVO*8-1:0] PwmReg,
    output logic                   Busy,
    output logic                   Irq
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [7:0] CENTER    = 8'h80;
    localparam logic [4:0] CTRL_ADDR = 5'd16;
    localparam logic [2:0] LAST_IDX  = 3'(NUM_SERVO - 1);

    state_t     state;
    logic [2:0] idx;
    logic       enable;

    logic [7:0] pos    [NUM_SERVO];
    logic [7:0] target [NUM_SERVO];
    logic [7:0] step   [NUM_SERVO];
    logic [7:0] pwm    [NUM_SERVO];

    logic       host_wr;
    logic       ctrl_wr;
    logic [7:0] sel_pos;
    logic [7:0] sel_target;
    logic [7:0] sel_step;
    logic [7:0] next_pos;
    logic       status_arrive;
    logic       status_overrun;

`ifdef SERVO_RAMP_IRQ_EN
    // Moved only feeds arrival detection, so it exists only with the IRQ feature.
    logic       moved;
    logic       arrive_pend;
    logic       overrun;
    logic       all_arrived;
`endif

    assign host_wr = En & Wr;
    assign ctrl_wr = host_wr && (Addr == CTRL_ADDR);
    assign Busy    = (state != IDLE);

    // One ramp step. The 9-bit distance keeps the compare exact; the step is
    // only applied when it cannot reach the target, so it never crosses
    // 0x00 or 0xFF.
    function automatic logic [7:0] ramp_step(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [7:0] stp);
        logic [8:0] diff;
        logic [7:0] moved_pos;
        logic [7:0] result;
        if (tgt >= cur) begin
            diff      = {1'b0, tgt} - {1'b0, cur};
            moved_pos = cur + stp;
        end else begin
            diff      = {1'b0, cur} - {1'b0, tgt};
            moved_pos = cur - stp;
        end
        if ((stp == 8'h00) || (diff <= {1'b0, stp}))
            result = tgt;
        else
            result = moved_pos;
        return result;
    endfunction

    // Select the channel being scanned and compute its next position.
    always_comb begin
        sel_pos    = CENTER;
        sel_target = CENTER;
        sel_step   = 8'h00;
        for (int i = 0; i < NUM_SERVO; i++) begin
            if (idx == 3'(i)) begin
                sel_pos    = pos[i];
                sel_target = target[i];
                sel_step   = step[i];
            end
        end
        next_pos = ramp_step(sel_pos, sel_target, sel_step);
    end

`ifdef SERVO_RAMP_IRQ_EN
    // True when every channel sits on its target.
    always_comb begin
        all_arrived = 1'b1;
        for (int i = 0; i < NUM_SERVO; i++) begin
            if (pos[i] != target[i])
                all_arrived = 1'b0;
        end
    end

    assign status_arrive  = arrive_pend;
    assign status_overrun = overrun;
    assign Irq            = arrive_pend;
`else
    assign status_arrive  = 1'b0;
    assign status_overrun = 1'b0;
    assign Irq            = 1'b0;
`endif

    // Host read mux; unmapped addresses read zero.
    always_comb begin
        DataRd = 16'h0000;
        for (int i = 0; i < NUM_SERVO; i++) begin
            if (Addr == 5'(i))
                DataRd = {step[i], target[i]};
            if (Addr == 5'(8 + i))
                DataRd = {8'h00, pos[i]};
        end
        if (Addr == CTRL_ADDR)
            DataRd = {12'h000, status_overrun, status_arrive, Busy, enable};
    end

    // Host-writable per-channel target and step registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_SERVO; i++) begin
                target[i] <= CENTER;
                step[i]   <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NUM_SERVO; i++) begin
                if (host_wr && (Addr == 5'(i))) begin
                    target[i] <= DataWr[7:0];
                    step[i]   <= DataWr[15:8];
                end
            end
        end
    end

    // Frame sequencer: scan channels one per cycle, then commit to the PWM bank.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            idx    <= 3'd0;
            enable <= 1'b0;
            for (int i = 0; i < NUM_SERVO; i++) begin
                pos[i] <= CENTER;
                pwm[i] <= CENTER;
            end
`ifdef SERVO_RAMP_IRQ_EN
            moved       <= 1'b0;
            arrive_pend <= 1'b0;
            overrun     <= 1'b0;
`endif
        end else begin
            if (ctrl_wr)
                enable <= DataWr[0];

            case (state)
                IDLE: begin
                    if (FrameTick && enable) begin
                        state <= SCAN;
                        idx   <= 3'd0;
`ifdef SERVO_RAMP_IRQ_EN
                        moved <= 1'b0;
`endif
                    end
                end
                SCAN: begin
                    for (int i = 0; i < NUM_SERVO; i++) begin
                        if (idx == 3'(i))
                            pos[i] <= next_pos;
                    end
`ifdef SERVO_RAMP_IRQ_EN
                    if (next_pos != sel_pos)
                        moved <= 1'b1;
`endif
                    if (idx == LAST_IDX)
                        state <= COMMIT;
                    else
                        idx <= idx + 3'd1;
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_SERVO; i++)
                        pwm[i] <= pos[i];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

`ifdef SERVO_RAMP_IRQ_EN
            // Hardware set takes priority over a simultaneous W1C.
            if ((state == COMMIT) && moved && all_arrived)
                arrive_pend <= 1'b1;
            else if (ctrl_wr && DataWr[2])
                arrive_pend <= 1'b0;

            if (FrameTick && (state != IDLE))
                overrun <= 1'b1;
            else if (ctrl_wr && DataWr[3])
                overrun <= 1'b0;
`endif
        end
    end

    generate
        for (genvar g = 0; g < NUM_SERVO; g++) begin : g_pwm_out
            assign PwmReg[8*g +: 8] = pwm[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_servo_ramp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_servo_ramp_sequencer
//  Description : Directed self-checking bench for servo_ramp_sequencer.
//                Expectations follow SERVO_RAMP_IRQ_EN when it is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_servo_ramp_sequencer;

    localparam int NS = 4;
`ifdef SERVO_RAMP_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    addr;
    logic [15:0]   data_wr;
    logic [15:0]   data_rd;
    logic          en;
    logic          wr;
    logic          frame_tick;
    logic [NS*8-1:0] pwm_reg;
    logic          busy;
    logic          irq;

    int checks = 0;
    int errors = 0;

    servo_ramp_sequencer #(.NUM_SERVO(NS)) dut (
        .Clk       (clk),
        .Reset     (reset),
        .Addr      (addr),
        .DataWr    (data_wr),
        .DataRd    (data_rd),
        .En        (en),
        .Wr        (wr),
        .FrameTick (frame_tick),
        .PwmReg    (pwm_reg),
        .Busy      (busy),
        .Irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [15:0] d);
        addr = a; data_wr = d; en = 1'b1; wr = 1'b1;
        tick();
        en = 1'b0; wr = 1'b0; data_wr = 16'h0000;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [15:0] exp);
        addr = a;
        #1;
        chk(tag, {16'h0, data_rd}, {16'h0, exp});
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        repeat (NS + 1) tick();
    endtask

    function automatic logic [15:0] st(input bit e, input bit b, input bit a, input bit o);
        return {12'h000, o & IRQ, a & IRQ, b, e};
    endfunction

    initial begin
        reset = 1'b1; addr = '0; data_wr = '0; en = 1'b0; wr = 1'b0; frame_tick = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_pwm", pwm_reg, 32'h80808080);
        reset = 1'b0;
        tick();
        rd_chk("rst_addr0", 5'd0, 16'h0080);
        rd_chk("rst_addr8", 5'd8, 16'h0080);
        rd_chk("rst_addr16", 5'd16, 16'h0000);
        rd_chk("unmapped5", 5'd5, 16'h0000);
        wr_reg(5'd12, 16'hFFFF);
        rd_chk("unmapped12", 5'd12, 16'h0000);
        rd_chk("ch0_untouched", 5'd0, 16'h0080);

        // Ramp up by one step, check commit latency
        wr_reg(5'd0, 16'h10A0);
        wr_reg(5'd16, 16'h0001);
        rd_chk("ch0_cfg", 5'd0, 16'h10A0);
        rd_chk("enable_set", 5'd16, 16'h0001);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        chk("scan_busy", {31'h0, busy}, 32'h1);
        rd_chk("status_busy", 5'd16, 16'h0003);
        repeat (NS) tick();
        chk("pwm_before_commit", pwm_reg, 32'h80808080);
        chk("commit_busy", {31'h0, busy}, 32'h1);
        tick();
        chk("pwm_at_commit", pwm_reg, 32'h80808090);
        chk("idle_busy", {31'h0, busy}, 32'h0);
        rd_chk("pos0_90", 5'd8, 16'h0090);
        rd_chk("no_arrive", 5'd16, st(1, 0, 0, 0));

        // Ch1 to 0x05, then down to 0x00 without wrapping
        wr_reg(5'd0, 16'h0090);
        wr_reg(5'd1, 16'h0005);
        frame();
        rd_chk("pos1_05", 5'd9, 16'h0005);
        chk("arrive1_irq", {31'h0, irq}, {31'h0, IRQ});
        wr_reg(5'd16, 16'h0005);
        chk("clr1_irq", {31'h0, irq}, 32'h0);
        wr_reg(5'd1, 16'h1000);
        frame();
        rd_chk("pos1_00", 5'd9, 16'h0000);
        chk("pwm_ch1_zero", pwm_reg, 32'h80800090);
        chk("arrive2_irq", {31'h0, irq}, {31'h0, IRQ});
        rd_chk("arrive2_status", 5'd16, st(1, 0, 1, 0));
        wr_reg(5'd16, 16'h0005);
        chk("clr2_irq", {31'h0, irq}, 32'h0);
        rd_chk("clr2_status", 5'd16, 16'h0001);

        // Multi-frame ramps, clamp at 0xFF, Step=0 jump
        wr_reg(5'd0, 16'h40FF);
        wr_reg(5'd2, 16'h0010);
        wr_reg(5'd3, 16'h2050);
        frame();
        chk("ramp_f1_pwm", pwm_reg, 32'h601000D0);
        rd_chk("pos2_step0", 5'd10, 16'h0010);
        chk("ramp_f1_irq", {31'h0, irq}, 32'h0);
        frame();
        chk("ramp_f2_pwm", pwm_reg, 32'h501000FF);
        rd_chk("pos0_ff", 5'd8, 16'h00FF);
        chk("ramp_f2_irq", {31'h0, irq}, {31'h0, IRQ});
        wr_reg(5'd16, 16'h0005);

        // Overrun: second tick on cycle 2 of the scan
        wr_reg(5'd2, 16'h1030);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        repeat (10) tick();
        rd_chk("ovr_pos2", 5'd10, 16'h0020);
        chk("ovr_pwm", pwm_reg, 32'h502000FF);
        chk("ovr_busy", {31'h0, busy}, 32'h0);
        rd_chk("ovr_status", 5'd16, st(1, 0, 0, 1));
        wr_reg(5'd16, 16'h0009);
        rd_chk("ovr_clr", 5'd16, 16'h0001);

        // Enable cleared mid-scan: scan still completes
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        wr_reg(5'd16, 16'h0000);
        repeat (NS) tick();
        chk("dis_pwm", pwm_reg, 32'h503000FF);
        rd_chk("dis_status", 5'd16, st(0, 0, 1, 0));
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        chk("dis_no_scan", {31'h0, busy}, 32'h0);
        tick();
        rd_chk("dis_no_ovr", 5'd16, st(0, 0, 1, 0));
        wr_reg(5'd16, 16'h0005);

        // Write to channel 0 while it is being processed
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        wr_reg(5'd0, 16'h0010);
        repeat (NS) tick();
        rd_chk("race_pos0_old", 5'd8, 16'h00FF);
        rd_chk("race_cfg_new", 5'd0, 16'h0010);
        chk("race_irq", {31'h0, irq}, 32'h0);
        frame();
        rd_chk("race_pos0_next", 5'd8, 16'h0010);
        chk("race_pwm_next", pwm_reg, 32'h50300010);
        chk("race_arrive_irq", {31'h0, irq}, {31'h0, IRQ});
        wr_reg(5'd16, 16'h0005);

        // Reset mid-scan abandons the frame
        wr_reg(5'd1, 16'h0040);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        tick();
        chk("midscan_busy", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        tick();
        chk("rst2_busy", {31'h0, busy}, 32'h0);
        chk("rst2_irq", {31'h0, irq}, 32'h0);
        chk("rst2_pwm", pwm_reg, 32'h80808080);
        reset = 1'b0;
        tick();
        rd_chk("rst2_pos1", 5'd9, 16'h0080);
        rd_chk("rst2_cfg1", 5'd1, 16'h0080);
        rd_chk("rst2_status", 5'd16, 16'h0000);
        repeat (6) tick();
        chk("rst2_pwm_hold", pwm_reg, 32'h80808080);
        chk("rst2_busy_hold", {31'h0, busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
